// File: rtl/pwm_level_sequencer_if.sv
// Signal bundle between the PWM/display datapath and the level sequencer.
// The master drives the button, period and hold inputs; the slave returns the levels.
interface pwm_level_sequencer_if;
    logic [1:0] btn;
    logic       period_end;
    logic       hold;
    logic [3:0] tgt0;
    logic [3:0] tgt1;
    logic [3:0] lvl0;
    logic [3:0] lvl1;
    logic [1:0] lvl_upd;
    logic [1:0] busy;

    modport master (
        output btn,
        output period_end,
        output hold,
        input  tgt0,
        input  tgt1,
        input  lvl0,
        input  lvl1,
        input  lvl_upd,
        input  busy
    );

    modport slave (
        input  btn,
        input  period_end,
        input  hold,
        output tgt0,
        output tgt1,
        output lvl0,
        output lvl1,
        output lvl_upd,
        output busy
    );
endinterface

// File: rtl/pwm_level_sequencer.sv
// Two-channel button debouncer, target-level counter and period-aligned level ramp.
// Applied levels only ever change on a period_end edge, one step at a time.
module pwm_level_sequencer #(
    parameter int DEB_CYCLES   = 20000,
    parameter int MAX_LEVEL    = 9,
    parameter int RAMP_PERIODS = 1
) (
    input logic                 clk,
    input logic                 rst,
    pwm_level_sequencer_if.slave bus
);
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RCNT_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RAMP_PERIODS - 1);
    localparam logic [3:0]        LVL_MAX   = 4'(MAX_LEVEL);

    logic [3:0] w_tgt [2];
    logic [3:0] w_lvl [2];
    logic [1:0] w_upd;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic              r_sync1;
            logic              r_sync2;
            logic              r_stable;
            logic              r_stable_d;
            logic [DEB_W-1:0]  r_deb_cnt;
            logic [3:0]        r_tgt;
            logic [3:0]        r_lvl;
            logic [RCNT_W-1:0] r_rcnt;
            logic              r_lvl_upd;
            logic              w_press;
            logic              w_ramp_active;

            assign w_press       = r_stable & ~r_stable_d;
            assign w_ramp_active = bus.period_end & ~bus.hold & (r_lvl != r_tgt);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_deb_cnt  <= '0;
                end else begin
                    r_sync1    <= bus.btn[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    if (r_sync2 == r_stable) begin
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_stable  <= r_sync2;
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tgt <= 4'd0;
                end else if (w_press) begin
                    r_tgt <= (r_tgt == LVL_MAX) ? 4'd0 : r_tgt + 4'd1;
                end
            end

            // Direction is taken from the registered target, so a press landing on
            // the same edge as a step only influences the following step.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lvl     <= 4'd0;
                    r_rcnt    <= '0;
                    r_lvl_upd <= 1'b0;
                end else begin
                    r_lvl_upd <= 1'b0;
                    if (w_ramp_active) begin
                        if (r_rcnt == RCNT_LAST) begin
                            r_lvl     <= (r_lvl < r_tgt) ? r_lvl + 4'd1 : r_lvl - 4'd1;
                            r_rcnt    <= '0;
                            r_lvl_upd <= 1'b1;
                        end else begin
                            r_rcnt <= r_rcnt + RCNT_W'(1);
                        end
                    end else if (r_lvl == r_tgt) begin
                        r_rcnt <= '0;
                    end
                end
            end

            assign w_tgt[gi] = r_tgt;
            assign w_lvl[gi] = r_lvl;
            assign w_upd[gi] = r_lvl_upd;
        end
    endgenerate

    assign bus.tgt0    = w_tgt[0];
    assign bus.tgt1    = w_tgt[1];
    assign bus.lvl0    = w_lvl[0];
    assign bus.lvl1    = w_lvl[1];
    assign bus.lvl_upd = w_upd;
    assign bus.busy    = {(w_lvl[1] != w_tgt[1]), (w_lvl[0] != w_tgt[0])};
endmodule

// File: tb/tb_pwm_level_sequencer.sv
// Scenario bench for pwm_level_sequencer: expected level steps are queued when
// period_end is driven and popped by a monitor whenever lvl_upd fires.
module tb_pwm_level_sequencer;
    localparam int DEB  = 4;
    localparam int MAXL = 9;
    localparam int RP   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_level_sequencer_if bus();

    pwm_level_sequencer #(
        .DEB_CYCLES  (DEB),
        .MAX_LEVEL   (MAXL),
        .RAMP_PERIODS(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q0 [$];
    logic [3:0] exp_q1 [$];
    logic [3:0] mon_e0;
    logic [3:0] mon_e1;

    // Scoreboard monitor: every lvl_upd pulse must match the next queued level.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.lvl_upd[0] === 1'b1) begin
                n_tests++;
                if (exp_q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL upd0_unexpected: lvl0=%0d, required no step", bus.lvl0);
                end else begin
                    mon_e0 = exp_q0.pop_front();
                    if (bus.lvl0 !== mon_e0) begin
                        n_fail++;
                        $display("FAIL step_lvl0: got %0d, required %0d", bus.lvl0, mon_e0);
                    end else
                        $display("[TB] step ch0 lvl0=%0d", bus.lvl0);
                end
            end
            if (bus.lvl_upd[1] === 1'b1) begin
                n_tests++;
                if (exp_q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL upd1_unexpected: lvl1=%0d, required no step", bus.lvl1);
                end else begin
                    mon_e1 = exp_q1.pop_front();
                    if (bus.lvl1 !== mon_e1) begin
                        n_fail++;
                        $display("FAIL step_lvl1: got %0d, required %0d", bus.lvl1, mon_e1);
                    end else
                        $display("[TB] step ch1 lvl1=%0d", bus.lvl1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int ch);
        bus.btn[ch] = 1'b1;
        tick(DEB + 3);
        bus.btn[ch] = 1'b0;
        tick(DEB + 3);
    endtask

    task automatic pulse_pe();
        bus.period_end = 1'b1;
        tick(1);
        bus.period_end = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        n_tests++; if (bus.tgt0 !== 4'd0) begin n_fail++; $display("FAIL rst_tgt0: got %0d, required 0", bus.tgt0); end
        n_tests++; if (bus.tgt1 !== 4'd0) begin n_fail++; $display("FAIL rst_tgt1: got %0d, required 0", bus.tgt1); end
        n_tests++; if (bus.lvl0 !== 4'd0) begin n_fail++; $display("FAIL rst_lvl0: got %0d, required 0", bus.lvl0); end
        n_tests++; if (bus.lvl1 !== 4'd0) begin n_fail++; $display("FAIL rst_lvl1: got %0d, required 0", bus.lvl1); end
        n_tests++; if (bus.lvl_upd !== 2'b00) begin n_fail++; $display("FAIL rst_upd: got %b, required 00", bus.lvl_upd); end
        n_tests++; if (bus.busy !== 2'b00) begin n_fail++; $display("FAIL rst_busy: got %b, required 00", bus.busy); end
        repeat (3) pulse_pe();
        n_tests++; if (bus.lvl0 !== 4'd0 || bus.lvl1 !== 4'd0) begin n_fail++; $display("FAIL idle_pe_lvl: got %0d/%0d, required 0/0", bus.lvl0, bus.lvl1); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_latency();
        bus.btn[0] = 1'b1;
        tick(6);
        n_tests++; if (bus.tgt0 !== 4'd0) begin n_fail++; $display("FAIL lat_early_tgt0: got %0d, required 0", bus.tgt0); end
        tick(1);
        n_tests++; if (bus.tgt0 !== 4'd1) begin n_fail++; $display("FAIL lat_tgt0: got %0d, required 1", bus.tgt0); end
        n_tests++; if (bus.tgt1 !== 4'd0) begin n_fail++; $display("FAIL lat_tgt1: got %0d, required 0", bus.tgt1); end
        n_tests++; if (bus.busy !== 2'b01) begin n_fail++; $display("FAIL lat_busy: got %b, required 01", bus.busy); end
        tick(3);
        bus.btn[0] = 1'b0;
        tick(DEB + 3);
        exp_q0.push_back(4'd1);
        pulse_pe();
        n_tests++; if (bus.lvl0 !== 4'd1) begin n_fail++; $display("FAIL lat_lvl0: got %0d, required 1", bus.lvl0); end
        n_tests++; if (bus.busy !== 2'b00) begin n_fail++; $display("FAIL lat_busy_done: got %b, required 00", bus.busy); end
        $display("[TB] test_latency done");
    endtask

    task automatic test_glitch_wrap();
        bus.btn[1] = 1'b1;
        tick(3);
        bus.btn[1] = 1'b0;
        tick(10);
        n_tests++; if (bus.tgt1 !== 4'd0) begin n_fail++; $display("FAIL glitch_tgt1: got %0d, required 0", bus.tgt1); end
        for (int k = 1; k <= 10; k++) begin
            press(1);
            n_tests++;
            if (bus.tgt1 !== 4'(k % 10)) begin
                n_fail++;
                $display("FAIL press_tgt1_%0d: got %0d, required %0d", k, bus.tgt1, k % 10);
            end else
                $display("[TB] press ch1 tgt1=%0d", bus.tgt1);
        end
    endtask

    task automatic test_wrap_down();
        for (int k = 0; k < 8; k++) press(0);
        n_tests++; if (bus.tgt0 !== 4'd9) begin n_fail++; $display("FAIL wrap_tgt0_9: got %0d, required 9", bus.tgt0); end
        for (int v = 2; v <= 8; v++) begin
            exp_q0.push_back(4'(v));
            pulse_pe();
        end
        // Press lands on the same edge as a step: step goes toward the old target 9.
        exp_q0.push_back(4'd9);
        bus.btn[0] = 1'b1;
        tick(6);
        bus.period_end = 1'b1;
        tick(1);
        bus.period_end = 1'b0;
        n_tests++; if (bus.tgt0 !== 4'd0) begin n_fail++; $display("FAIL coinc_tgt0: got %0d, required 0", bus.tgt0); end
        n_tests++; if (bus.lvl0 !== 4'd9) begin n_fail++; $display("FAIL coinc_lvl0: got %0d, required 9", bus.lvl0); end
        bus.btn[0] = 1'b0;
        tick(DEB + 3);
        for (int v = 8; v >= 0; v--) begin
            exp_q0.push_back(4'(v));
            pulse_pe();
        end
        n_tests++; if (bus.lvl0 !== 4'd0) begin n_fail++; $display("FAIL down_lvl0: got %0d, required 0", bus.lvl0); end
        n_tests++; if (bus.busy !== 2'b00) begin n_fail++; $display("FAIL down_busy: got %b, required 00", bus.busy); end
    endtask

    task automatic test_hold();
        press(0);
        press(0);
        exp_q0.push_back(4'd1);
        pulse_pe();
        exp_q0.push_back(4'd2);
        pulse_pe();
        repeat (3) press(0);
        n_tests++; if (bus.tgt0 !== 4'd5) begin n_fail++; $display("FAIL hold_tgt0: got %0d, required 5", bus.tgt0); end
        bus.hold = 1'b1;
        repeat (3) pulse_pe();
        n_tests++; if (bus.lvl0 !== 4'd2) begin n_fail++; $display("FAIL hold_lvl0: got %0d, required 2", bus.lvl0); end
        n_tests++; if (bus.busy !== 2'b01) begin n_fail++; $display("FAIL hold_busy: got %b, required 01", bus.busy); end
        bus.hold = 1'b0;
        for (int v = 3; v <= 5; v++) begin
            exp_q0.push_back(4'(v));
            pulse_pe();
        end
        n_tests++; if (bus.lvl0 !== 4'd5) begin n_fail++; $display("FAIL unhold_lvl0: got %0d, required 5", bus.lvl0); end
    endtask

    task automatic test_reset_mid();
        repeat (7) press(1);
        for (int v = 1; v <= 4; v++) begin
            exp_q1.push_back(4'(v));
            pulse_pe();
        end
        n_tests++; if (bus.lvl1 !== 4'd4 || bus.tgt1 !== 4'd7) begin n_fail++; $display("FAIL mid_state: got lvl1=%0d tgt1=%0d, required 4/7", bus.lvl1, bus.tgt1); end
        bus.btn[0] = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        n_tests++; if (bus.tgt0 !== 4'd0 || bus.tgt1 !== 4'd0) begin n_fail++; $display("FAIL mid_rst_tgt: got %0d/%0d, required 0/0", bus.tgt0, bus.tgt1); end
        n_tests++; if (bus.lvl0 !== 4'd0 || bus.lvl1 !== 4'd0) begin n_fail++; $display("FAIL mid_rst_lvl: got %0d/%0d, required 0/0", bus.lvl0, bus.lvl1); end
        n_tests++; if (bus.busy !== 2'b00 || bus.lvl_upd !== 2'b00) begin n_fail++; $display("FAIL mid_rst_flags: got busy=%b upd=%b, required 00/00", bus.busy, bus.lvl_upd); end
        rst = 1'b0;
        bus.btn[0] = 1'b0;
        tick(DEB + 6);
        n_tests++; if (bus.tgt0 !== 4'd0) begin n_fail++; $display("FAIL abandoned_press: got %0d, required 0", bus.tgt0); end
        press(0);
        n_tests++; if (bus.tgt0 !== 4'd1) begin n_fail++; $display("FAIL post_rst_press: got %0d, required 1", bus.tgt0); end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        bus.btn        = 2'b00;
        bus.period_end = 1'b0;
        bus.hold       = 1'b0;
        test_reset();
        test_latency();
        test_glitch_wrap();
        test_wrap_down();
        test_hold();
        test_reset_mid();
        tick(2);
        n_tests++; if (exp_q0.size() != 0) begin n_fail++; $display("FAIL q0_drained: got %0d pending, required 0", exp_q0.size()); end
        n_tests++; if (exp_q1.size() != 0) begin n_fail++; $display("FAIL q1_drained: got %0d pending, required 0", exp_q1.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
